// File: rtl/reg_read_pkg.sv
// Shared constants and buffer-occupancy encoding for the register-file read port.
package reg_read_pkg;

  localparam int         NUM_REGS = 32;
  localparam logic [4:0] XZR_ADDR = 5'd31;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_t;

endpackage

// File: rtl/reg_read_port_buffer.sv
// Two-entry operand-pair response buffer: head/tail pointers plus an occupancy FSM.
// Handshake: a push happens when in_valid is high and the buffer is not FULL; a pop happens
// when the buffer is not EMPTY and out_ready is high; both take effect on the same posedge.
module reg_read_buffer
  import reg_read_pkg::*;
#(
  parameter int SIZE = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [SIZE-1:0] in_a,
  input  logic [SIZE-1:0] in_b,
  input  logic            out_ready,
  output logic [SIZE-1:0] out_a,
  output logic [SIZE-1:0] out_b,
  output buf_state_t      state
);

  buf_state_t      state_q, state_d;
  logic            head_q, head_d;
  logic            tail_q, tail_d;
  logic            push, pop;
  logic [1:0]      wren;
  logic [SIZE-1:0] ent_a [2];
  logic [SIZE-1:0] ent_b [2];

  assign push = in_valid && (state_q != FULL);
  assign pop  = out_ready && (state_q != EMPTY);

  always_comb begin
    wren         = 2'b00;
    wren[tail_q] = push;
  end

  for (genvar e = 0; e < 2; e++) begin : g_entry
    registerEnabled #(.SIZE(SIZE)) u_ent_a (
      .clk   (clk),
      .reset (reset),
      .wren  (wren[e]),
      .d     (in_a),
      .q     (ent_a[e])
    );
    registerEnabled #(.SIZE(SIZE)) u_ent_b (
      .clk   (clk),
      .reset (reset),
      .wren  (wren[e]),
      .d     (in_b),
      .q     (ent_b[e])
    );
  end

  // A simultaneous push and pop in ONE moves the head onto the entry being written.
  always_comb begin
    head_d  = head_q ^ pop;
    tail_d  = tail_q ^ push;
    state_d = state_q;
    case (state_q)
      EMPTY:   if (push) state_d = ONE;
      ONE: begin
        if (push && !pop)      state_d = FULL;
        else if (!push && pop) state_d = EMPTY;
      end
      FULL:    if (pop) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= EMPTY;
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  assign out_a = ent_a[head_q];
  assign out_b = ent_b[head_q];
  assign state = state_q;

endmodule

// File: rtl/register_enabled.sv
// Resettable storage register that loads d only when wren is high.
module registerEnabled #(
  parameter int SIZE = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wren,
  input  logic [SIZE-1:0] d,
  output logic [SIZE-1:0] q
);

  logic [SIZE-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (wren) q_d = d;
  end

  always_ff @(posedge clk) begin
    if (!reset) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/reg_read_port.sv
// Register-file read port: operand select (XZR, write bypass, array data) into a
// two-entry response buffer with valid/ready handshakes on both sides.
module reg_read_port
  import reg_read_pkg::*;
#(
  parameter int SIZE   = 64,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addrA,
  input  logic [ADDR_W-1:0] req_addrB,
  output logic [ADDR_W-1:0] rf_addrA,
  output logic [ADDR_W-1:0] rf_addrB,
  input  logic [SIZE-1:0]   rf_dataA,
  input  logic [SIZE-1:0]   rf_dataB,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [SIZE-1:0]   wr_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [SIZE-1:0]   rsp_dataA,
  output logic [SIZE-1:0]   rsp_dataB
);

  localparam logic [ADDR_W-1:0] XZR = ADDR_W'(XZR_ADDR);

  logic [SIZE-1:0] op_a, op_b;
  buf_state_t      buf_state;

  assign rf_addrA = req_addrA;
  assign rf_addrB = req_addrB;

  // XZR has priority over a bypass so a write aimed at X31 can never leak through.
  always_comb begin
    op_a = rf_dataA;
    op_b = rf_dataB;
    if (wr_en && (wr_addr == req_addrA)) op_a = wr_data;
    if (wr_en && (wr_addr == req_addrB)) op_b = wr_data;
    if (req_addrA == XZR) op_a = '0;
    if (req_addrB == XZR) op_b = '0;
  end

  reg_read_buffer #(.SIZE(SIZE)) u_buf (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (req_valid),
    .in_a      (op_a),
    .in_b      (op_b),
    .out_ready (rsp_ready),
    .out_a     (rsp_dataA),
    .out_b     (rsp_dataB),
    .state     (buf_state)
  );

  assign req_ready = (buf_state != FULL);
  assign rsp_valid = (buf_state != EMPTY);

endmodule
